mem_port_arbiter: RTL and testbench

- Shares one single-port backing memory between instruction fetch (IF stage, PC/IF_ID side) and data access (MEM stage, ALU_MEM side).
- Serialises requests, handles the variable-latency memory handshake, and returns read data.
- Generates the stall (lock) signals that freeze the PC, IF_ID, DEC_ALU and ALU_MEM while an access is outstanding.
- Data requests have priority, with a starvation limit that guarantees fetch progress.

---
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 99 +++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch-side, data-side and backing-memory handshake signals around the shared memory port.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ifReq;
  logic [ADDR_W-1:0] ifAddr;
  logic              ifValid;
  logic [DATA_W-1:0] ifData;
  logic              ifLock;

  logic              dReq;
  logic              dWe;
  logic [ADDR_W-1:0] dAddr;
  logic [DATA_W-1:0] dWdata;
  logic              dValid;
  logic [DATA_W-1:0] dRdata;
  logic              dLock;

  logic              mReq;
  logic              mWe;
  logic [ADDR_W-1:0] mAddr;
  logic [DATA_W-1:0] mWdata;
  logic [DATA_W-1:0] mRdata;
  logic              mAck;

  logic              busy;

  // The arbiter itself sits on the slave side
  modport slave (
    input  ifReq, ifAddr, dReq, dWe, dAddr, dWdata, mRdata, mAck,
    output ifValid, ifData, ifLock, dValid, dRdata, dLock,
    output mReq, mWe, mAddr, mWdata, busy
  );

  modport master (
    output ifReq, ifAddr, dReq, dWe, dAddr, dWdata, mRdata, mAck,
    input  ifValid, ifData, ifLock, dValid, dRdata, dLock,
    input  mReq, mWe, mAddr, mWdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-port memory,
// data first, with a streak limit that guarantees fetch progress.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

  typedef enum logic [1:0] {IDLE, IF_WAIT, D_WAIT, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              grant_d;
  logic              grant_if;
  logic [3:0]        d_streak;
  logic              resp_is_d;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] if_data;
  logic [DATA_W-1:0] d_rdata;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= STREAK_MAX) ? STREAK_MAX : v + 4'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_if  = 1'b0;
    case (state)
      IDLE: begin
        // Data wins unless fetch has waited through a full streak of data grants
        if (bus.dReq && !(bus.ifReq && d_streak == STREAK_MAX)) begin
          grant_d   = 1'b1;
          state_nxt = D_WAIT;
        end else if (bus.ifReq) begin
          grant_if  = 1'b1;
          state_nxt = IF_WAIT;
        end
      end
      IF_WAIT, D_WAIT: if (bus.mAck) state_nxt = RESP;
      RESP:            state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      d_streak  <= 4'd0;
      resp_is_d <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      if_data   <= '0;
      d_rdata   <= '0;
    end else begin
      if (grant_d) begin
        m_we      <= bus.dWe;
        m_addr    <= bus.dAddr;
        m_wdata   <= bus.dWdata;
        resp_is_d <= 1'b1;
        d_streak  <= bus.ifReq ? sat_inc(d_streak) : 4'd0;
      end else if (grant_if) begin
        m_we      <= 1'b0;
        m_addr    <= bus.ifAddr;
        resp_is_d <= 1'b0;
        d_streak  <= 4'd0;
      end
      if (bus.mAck && state == IF_WAIT) if_data <= bus.mRdata;
      // A completed store reports zero read data
      if (bus.mAck && state == D_WAIT)  d_rdata <= m_we ? '0 : bus.mRdata;
    end
  end

  assign bus.mReq    = (state == IF_WAIT) || (state == D_WAIT);
  assign bus.mWe     = m_we;
  assign bus.mAddr   = m_addr;
  assign bus.mWdata  = m_wdata;
  assign bus.busy    = (state != IDLE);
  assign bus.ifValid = (state == RESP) && !resp_is_d;
  assign bus.dValid  = (state == RESP) && resp_is_d;
  assign bus.ifData  = if_data;
  assign bus.dRdata  = d_rdata;
  assign bus.ifLock  = bus.ifReq & ~bus.ifValid;
  assign bus.dLock   = bus.dReq & ~bus.dValid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: expected grants and responses are queued by the stimulus
// and consumed by a monitor watching mReq rises and valid pulses.
module tb_mem_port_arbiter;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int MAX_DSTREAK = 4;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ack_auto;
  logic        ack_force;
  logic        mem_en;
  logic [31:0] mem_rdata;
  int          ack_dly;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          last_len = 0;
  resp_t       exp_resp[$];
  grant_t      exp_grant[$];

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DSTREAK(MAX_DSTREAK)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  assign bus.mAck   = ack_auto | ack_force;
  assign bus.mRdata = mem_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic exp_g(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    grant_t g;
    g.we = we; g.addr = addr; g.wdata = wdata;
    exp_grant.push_back(g);
  endtask

  task automatic exp_r(input bit is_d, input logic [31:0] data);
    resp_t r;
    r.is_d = is_d; r.data = data;
    exp_resp.push_back(r);
  endtask

  task automatic wait_valid(input bit is_d, input string name);
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (is_d ? bus.dValid : bus.ifValid) break;
    end
    if (i == 40) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  // Memory model: acks ack_dly cycles after first seeing mReq
  initial begin
    int cnt;
    cnt = 0;
    ack_auto = 1'b0;
    forever begin
      @(posedge clk); #1;
      ack_auto = 1'b0;
      if (mem_en && bus.mReq) begin
        if (cnt >= ack_dly) begin
          ack_auto = 1'b1;
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  // Monitor: grant contents on mReq rise, hold stability, and valid responses
  initial begin
    grant_t g;
    grant_t cur;
    resp_t  r;
    logic   prev;
    int     run_len;
    prev = 1'b0;
    run_len = 0;
    cur.we = 1'b0; cur.addr = '0; cur.wdata = '0;
    forever begin
      @(negedge clk);
      if (bus.ifValid || bus.dValid) begin
        check("one_valid", 32'(bus.ifValid & bus.dValid), 32'd0);
        if (exp_resp.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
        else begin
          r = exp_resp.pop_front();
          check("valid_kind", 32'(bus.dValid), 32'(r.is_d));
          check("valid_data", bus.dValid ? bus.dRdata : bus.ifData, r.data);
        end
      end
      if (bus.mReq && !prev) begin
        if (exp_grant.size() == 0) check("unexpected_grant", 32'd1, 32'd0);
        else begin
          g = exp_grant.pop_front();
          check("grant_we", 32'(bus.mWe), 32'(g.we));
          check("grant_addr", bus.mAddr, g.addr);
          if (g.we) check("grant_wdata", bus.mWdata, g.wdata);
        end
        cur.we = bus.mWe; cur.addr = bus.mAddr; cur.wdata = bus.mWdata;
        run_len = 1;
      end else if (bus.mReq) begin
        check("hold_stable", 32'(bus.mWe === cur.we && bus.mAddr === cur.addr &&
                                 bus.mWdata === cur.wdata), 32'd1);
        run_len++;
      end else if (prev) begin
        last_len = run_len;
      end
      prev = bus.mReq;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv;
    reset = 1'b0; mem_en = 1'b1; ack_force = 1'b0; ack_dly = 0; mem_rdata = '0;
    bus.ifReq = 1'b0; bus.ifAddr = '0;
    bus.dReq = 1'b0; bus.dWe = 1'b0; bus.dAddr = '0; bus.dWdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mreq", 32'(bus.mReq), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valids", 32'({bus.ifValid, bus.dValid}), 32'd0);
    check("rst_mwe", 32'(bus.mWe), 32'd0);
    check("rst_maddr", bus.mAddr, 32'd0);
    check("rst_mwdata", bus.mWdata, 32'd0);
    check("rst_ifdata", bus.ifData, 32'd0);
    check("rst_drdata", bus.dRdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Single fetch, immediate ack
    ack_dly = 0; mem_rdata = 32'h00A00093;
    exp_g(1'b0, 32'h10, 32'h0);
    exp_r(1'b0, 32'h00A00093);
    bus.ifReq = 1'b1; bus.ifAddr = 32'h10;
    @(negedge clk);
    check("fetch_lock_before", 32'(bus.ifLock), 32'd1);
    wait_valid(1'b0, "fetch");
    check("fetch_lock_at_valid", 32'(bus.ifLock), 32'd0);
    @(posedge clk); #1;
    bus.ifReq = 1'b0; bus.ifAddr = 32'hFFFF_FFFF;
    check("fetch_mreq_len", last_len, 32'd1);
    repeat (2) @(posedge clk); #1;

    // Load, then a fetch that must leave dRdata alone
    ack_dly = 1; mem_rdata = 32'h12345678;
    exp_g(1'b0, 32'h0F, 32'h0);
    exp_r(1'b1, 32'h12345678);
    bus.dReq = 1'b1; bus.dWe = 1'b0; bus.dAddr = 32'h0F;
    @(negedge clk);
    check("load_lock_before", 32'(bus.dLock), 32'd1);
    wait_valid(1'b1, "load");
    check("load_lock_at_valid", 32'(bus.dLock), 32'd0);
    @(posedge clk); #1;
    bus.dReq = 1'b0;
    check("load_mreq_len", last_len, 32'd2);
    @(posedge clk); #1;
    mem_rdata = 32'hCAFEF00D;
    exp_g(1'b0, 32'h20, 32'h0);
    exp_r(1'b0, 32'hCAFEF00D);
    bus.ifReq = 1'b1; bus.ifAddr = 32'h20;
    wait_valid(1'b0, "fetch2");
    @(posedge clk); #1;
    bus.ifReq = 1'b0;
    check("drdata_kept", bus.dRdata, 32'h12345678);
    check("ifdata_fetch2", bus.ifData, 32'hCAFEF00D);
    repeat (2) @(posedge clk); #1;

    // Store with a slow memory; mRdata is noise and must not reach dRdata
    ack_dly = 2; mem_rdata = 32'hFFFF_FFFF;
    exp_g(1'b1, 32'h3C, 32'hDEADBEEF);
    exp_r(1'b1, 32'h0);
    bus.dReq = 1'b1; bus.dWe = 1'b1; bus.dAddr = 32'h3C; bus.dWdata = 32'hDEADBEEF;
    wait_valid(1'b1, "store");
    @(posedge clk); #1;
    bus.dReq = 1'b0; bus.dWe = 1'b0;
    check("store_mreq_len", last_len, 32'd3);
    check("ifdata_hold", bus.ifData, 32'hCAFEF00D);
    repeat (2) @(posedge clk); #1;

    // Both held: four data grants then one forced fetch, twice
    ack_dly = 0; mem_rdata = 32'h55;
    for (int k = 0; k < 10; k++) begin
      exp_g(1'b0, ((k % 5) != 4) ? 32'h100 : 32'h200, 32'h0);
      exp_r((k % 5) != 4, 32'h55);
    end
    bus.dReq = 1'b1; bus.dWe = 1'b0; bus.dAddr = 32'h100;
    bus.ifReq = 1'b1; bus.ifAddr = 32'h200;
    nv = 0;
    for (int i = 0; i < 100 && nv < 10; i++) begin
      @(negedge clk);
      if (bus.ifValid || bus.dValid) nv++;
    end
    if (nv < 10) check("streak_timeout", 32'(nv), 32'd10);
    @(posedge clk); #1;
    bus.dReq = 1'b0; bus.ifReq = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reset during D_WAIT with the ack arriving after the reset
    mem_en = 1'b0;
    exp_g(1'b1, 32'h44, 32'h0BADF00D);
    bus.dReq = 1'b1; bus.dWe = 1'b1; bus.dAddr = 32'h44; bus.dWdata = 32'h0BADF00D;
    nv = 0;
    for (int i = 0; i < 20 && !bus.mReq; i++) @(negedge clk);
    if (!bus.mReq) check("rstmid_grant_timeout", 32'd0, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; bus.dReq = 1'b0; bus.dWe = 1'b0; ack_force = 1'b1;
    check("rstmid_mreq", 32'(bus.mReq), 32'd0);
    check("rstmid_busy", 32'(bus.busy), 32'd0);
    check("rstmid_drdata", bus.dRdata, 32'd0);
    check("rstmid_maddr", bus.mAddr, 32'd0);
    @(posedge clk); #1;
    ack_force = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rstmid_after_busy", 32'(bus.busy | bus.mReq | bus.dValid), 32'd0);
    end
    mem_en = 1'b1;

    // Spurious ack while idle
    @(posedge clk); #1;
    ack_force = 1'b1;
    @(posedge clk); #1;
    ack_force = 1'b0;
    check("spur_busy", 32'(bus.busy), 32'd0);
    check("spur_mreq", 32'(bus.mReq), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("spur_valids", 32'({bus.ifValid, bus.dValid, bus.busy}), 32'd0);
    end

    check("resp_queue_drained", 32'(exp_resp.size()), 32'd0);
    check("grant_queue_drained", 32'(exp_grant.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
